timer_cmp_out: RTL and testbench

Output-compare channel for the timer IP, driving an external compare pin. It is the output-direction counterpart of the capture input: instead of sampling an external edge, it generates edges, levels, PWM or a one-shot pulse from its own prescaled counter. It sits beside the capture/interrupt core inside the timer, fed by the APB register block, and exposes `cmpch_o` at the pad plus per-event pulses for interrupt logic.

---
 rtl/timer_cmp_out_pkg.sv | 50 +++++
 rtl/timer_cmp_out_psc.sv | 48 ++++
 rtl/timer_cmp_out.sv | 128 ++++++++++++
 tb/tb_timer_cmp_out.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/timer_cmp_out_pkg.sv
// Shared timer definitions: output-compare mode codes, prescaler floor
// and the pin-level helpers used by the compare channel.
package timer_cmp_out_pkg;

  localparam logic [2:0] TIM_OCM_NONE = 3'b000;
  localparam logic [2:0] TIM_OCM_SET  = 3'b001;
  localparam logic [2:0] TIM_OCM_CLR  = 3'b010;
  localparam logic [2:0] TIM_OCM_TOG  = 3'b011;
  localparam logic [2:0] TIM_OCM_PWM  = 3'b100;
  localparam logic [2:0] TIM_OCM_ONE  = 3'b101;

  localparam int TIM_PSCR_MIN_VAL = 2;

  // Active level is ~pol, idle level is pol.
  function automatic logic ocm_pin(
    input logic [2:0] mode,
    input logic       pin,
    input logic       hit,
    input logic       lt,
    input logic       pol
  );
    logic r;
    r = pol;
    case (mode)
      TIM_OCM_SET: r = hit ? ~pol : pin;
      TIM_OCM_CLR: r = hit ? pol : pin;
      TIM_OCM_TOG: r = hit ? ~pin : pin;
      TIM_OCM_PWM: r = lt ? ~pol : pol;
      TIM_OCM_ONE: r = hit ? pol : pin;
      default:     r = pol;
    endcase
    return r;
  endfunction

  function automatic logic ocm_start(
    input logic [2:0] mode,
    input logic       cmp_nz,
    input logic       pol
  );
    logic r;
    r = pol;
    case (mode)
      TIM_OCM_ONE: r = ~pol;
      TIM_OCM_PWM: r = cmp_nz ? ~pol : pol;
      default:     r = pol;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/timer_cmp_out_psc.sv
// Prescale tick generator: one tick every max(div, 2) clocks while enabled.
// Divisor is captured at enable start and again on every tick.
module timer_psc
  import timer_cmp_out_pkg::*;
#(
  parameter int PSCR_WIDTH = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [PSCR_WIDTH-1:0] div_i,
  output logic                  tick_o
);

  localparam logic [PSCR_WIDTH-1:0] DIV_MIN =
    PSCR_WIDTH'(TIM_PSCR_MIN_VAL);
  localparam logic [PSCR_WIDTH-1:0] ONE =
    PSCR_WIDTH'(1);

  logic                  en_q;
  logic [PSCR_WIDTH-1:0] cnt;
  logic [PSCR_WIDTH-1:0] div_q;
  logic [PSCR_WIDTH-1:0] div_c;
  logic                  start;

  assign div_c  = (div_i < DIV_MIN) ? DIV_MIN : div_i;
  assign start  = en_i & ~en_q;
  assign tick_o = en_i & en_q & (cnt == div_q - ONE);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q  <= 1'b0;
      cnt   <= '0;
      div_q <= '0;
    end else begin
      en_q <= en_i;
      if (!en_i) begin
        cnt <= '0;
      end else if (start || tick_o) begin
        cnt   <= '0;
        div_q <= div_c;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

endmodule

// File: rtl/timer_cmp_out.sv
// Output-compare channel: prescaled counter with shadowed period/compare/mode
// driving a registered compare pin plus match/overflow event pulses.
module timer_cmp_out
  import timer_cmp_out_pkg::*;
#(
  parameter int CNT_WIDTH  = 32,
  parameter int PSCR_WIDTH = 20
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  en_i,
  input  logic [2:0]            mode_i,
  input  logic                  pol_i,
  input  logic [PSCR_WIDTH-1:0] pscr_i,
  input  logic [CNT_WIDTH-1:0]  prd_i,
  input  logic [CNT_WIDTH-1:0]  cmp_i,
  output logic                  cmpch_o,
  output logic [CNT_WIDTH-1:0]  cnt_o,
  output logic                  match_o,
  output logic                  ovf_o,
  output logic                  busy_o
);

  logic                 en_q;
  logic                 tick;
  logic                 start;
  logic                 run;
  logic                 wrap;
  logic                 hit;
  logic                 lt;
  logic                 halt;
  logic                 load;
  logic [CNT_WIDTH-1:0] prd_sh;
  logic [CNT_WIDTH-1:0] cmp_sh;
  logic [2:0]           mode_sh;
  logic [CNT_WIDTH-1:0] cnt_nx;
  logic [CNT_WIDTH-1:0] cmp_eff;
  logic [2:0]           mode_eff;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 pin_d;
  logic                 busy_d;
  logic                 match_d;
  logic                 ovf_d;

  timer_psc #(
    .PSCR_WIDTH(PSCR_WIDTH)
  ) u_psc (
    .clk_i  (clk_i),
    .rst_n_i(rst_n_i),
    .en_i   (en_i),
    .div_i  (pscr_i),
    .tick_o (tick)
  );

  assign start = en_i & ~en_q;
  assign run   = en_i & en_q & busy_o & tick;
  assign wrap  = (cnt_o == prd_sh);

  // At a wrap the freshly loaded shadows already govern the action.
  assign cnt_nx   = wrap ? '0 : cnt_o + CNT_WIDTH'(1);
  assign cmp_eff  = wrap ? cmp_i : cmp_sh;
  assign mode_eff = wrap ? mode_i : mode_sh;
  assign hit      = (cnt_nx == cmp_eff);
  assign lt       = (cnt_nx < cmp_eff);
  assign halt     = wrap & (mode_sh == TIM_OCM_ONE);

  always_comb begin
    cnt_d   = cnt_o;
    pin_d   = cmpch_o;
    busy_d  = busy_o;
    match_d = 1'b0;
    ovf_d   = 1'b0;
    load    = 1'b0;
    unique case (1'b1)
      !en_i: begin
        cnt_d  = '0;
        busy_d = 1'b0;
        pin_d  = pol_i;
      end
      start: begin
        load   = 1'b1;
        cnt_d  = '0;
        busy_d = 1'b1;
        pin_d  = ocm_start(mode_i, |cmp_i, pol_i);
      end
      run: begin
        cnt_d = cnt_nx;
        ovf_d = wrap;
        load  = wrap;
        if (halt) begin
          busy_d = 1'b0;
          pin_d  = pol_i;
        end else begin
          match_d = hit;
          pin_d   = ocm_pin(mode_eff, cmpch_o, hit, lt, pol_i);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      en_q    <= 1'b0;
      cnt_o   <= '0;
      cmpch_o <= 1'b0;
      busy_o  <= 1'b0;
      match_o <= 1'b0;
      ovf_o   <= 1'b0;
      prd_sh  <= '0;
      cmp_sh  <= '0;
      mode_sh <= TIM_OCM_NONE;
    end else begin
      en_q    <= en_i;
      cnt_o   <= cnt_d;
      cmpch_o <= pin_d;
      busy_o  <= busy_d;
      match_o <= match_d;
      ovf_o   <= ovf_d;
      if (load) begin
        prd_sh  <= prd_i;
        cmp_sh  <= cmp_i;
        mode_sh <= mode_i;
      end
    end
  end

endmodule

// File: tb/tb_timer_cmp_out.sv
// Directed bench for timer_cmp_out: windowed pulse/level counts
// against hand-computed values.
module tb_timer_cmp_out;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        pol = 1'b0;
  logic [2:0]  mode = 3'd0;
  logic [19:0] pscr = '0;
  logic [31:0] prd = '0;
  logic [31:0] cmp = '0;
  logic        cmpch;
  logic        match;
  logic        ovf;
  logic        busy;
  logic [31:0] cnt;

  int n_chk = 0;
  int n_err = 0;
  int hi, no, nm, nb, fo, fm;

  always #5 clk = ~clk;

  timer_cmp_out dut (
    .clk_i  (clk),
    .rst_n_i(rst_n),
    .en_i   (en),
    .mode_i (mode),
    .pol_i  (pol),
    .pscr_i (pscr),
    .prd_i  (prd),
    .cmp_i  (cmp),
    .cmpch_o(cmpch),
    .cnt_o  (cnt),
    .match_o(match),
    .ovf_o  (ovf),
    .busy_o (busy)
  );

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic run_count(
    input  int n,
    output int h, output int o, output int m, output int b,
    output int f_o, output int f_m
  );
    h = 0; o = 0; m = 0; b = 0; f_o = -1; f_m = -1;
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      h += int'(cmpch);
      o += int'(ovf);
      m += int'(match);
      b += int'(busy);
      if (ovf && f_o < 0) f_o = i;
      if (match && f_m < 0) f_m = i;
    end
  endtask

  task automatic cfg_start(
    input logic [2:0] m, input int ps, input int pr,
    input int cm, input logic pl
  );
    en = 1'b0;
    @(posedge clk); #1;
    mode = m; pscr = 20'(ps); prd = 32'(pr);
    cmp = 32'(cm); pol = pl; en = 1'b1;
  endtask

  initial begin
    #3;
    chk("rst_pin", cmpch, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pulses", {match, ovf}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // PWM 3/10, prescale 2
    cfg_start(3'b100, 2, 9, 3, 1'b0);
    run_count(20, hi, no, nm, nb, fo, fm);
    chk("pwm_hi1", hi, 6);
    chk("pwm_match1", nm, 1);
    chk("pwm_mpos1", fm, 6);
    chk("pwm_busy1", nb, 20);
    run_count(20, hi, no, nm, nb, fo, fm);
    chk("pwm_hi2", hi, 6);
    chk("pwm_ovf2", no, 1);
    chk("pwm_opos2", fo, 0);

    // Toggle every 20 clocks
    cfg_start(3'b011, 4, 4, 2, 1'b0);
    run_count(20, hi, no, nm, nb, fo, fm);
    chk("tog_hi1", hi, 12);
    chk("tog_mpos1", fm, 8);
    chk("tog_ovf1", no, 0);
    run_count(20, hi, no, nm, nb, fo, fm);
    chk("tog_hi2", hi, 8);
    chk("tog_ovf2", no, 1);
    chk("tog_match2", nm, 1);
    chk("tog_gap", fm - fo, 8);
    run_count(20, hi, no, nm, nb, fo, fm);
    chk("tog_hi3", hi, 12);

    // One-shot
    cfg_start(3'b101, 2, 7, 5, 1'b0);
    run_count(20, hi, no, nm, nb, fo, fm);
    chk("one_hi", hi, 10);
    chk("one_match", nm, 1);
    chk("one_ovf", no, 1);
    chk("one_busy", nb, 16);
    chk("one_halt_busy", busy, 0);
    chk("one_halt_cnt", cnt, 0);
    run_count(20, hi, no, nm, nb, fo, fm);
    chk("one_quiet", hi + no + nm + nb, 0);
    cfg_start(3'b101, 2, 7, 5, 1'b0);
    run_count(1, hi, no, nm, nb, fo, fm);
    chk("one_rearm_pin", hi, 1);
    chk("one_rearm_busy", nb, 1);

    // Shadowed compare change mid-period
    cfg_start(3'b100, 2, 9, 3, 1'b0);
    run_count(11, hi, no, nm, nb, fo, fm);
    chk("sh_hi_a", hi, 6);
    chk("sh_cnt5", cnt, 5);
    cmp = 32'd7;
    run_count(9, hi, no, nm, nb, fo, fm);
    chk("sh_hi_b", hi, 0);
    run_count(20, hi, no, nm, nb, fo, fm);
    chk("sh_hi_next", hi, 14);
    chk("sh_mpos", fm, 14);

    // Duty boundaries
    cfg_start(3'b100, 2, 9, 0, 1'b0);
    run_count(40, hi, no, nm, nb, fo, fm);
    chk("cmp0_hi", hi, 0);
    cfg_start(3'b100, 2, 9, 12, 1'b0);
    run_count(40, hi, no, nm, nb, fo, fm);
    chk("cmp12_hi", hi, 40);
    chk("cmp12_match", nm, 0);

    // Prescale clamp
    for (int p = 0; p < 2; p++) begin
      cfg_start(3'b100, p, 9, 3, 1'b0);
      run_count(20, hi, no, nm, nb, fo, fm);
      chk($sformatf("psc%0d_hi", p), hi, 6);
      chk($sformatf("psc%0d_mpos", p), fm, 6);
      run_count(20, hi, no, nm, nb, fo, fm);
      chk($sformatf("psc%0d_opos", p), fo, 0);
    end

    // Zero period: wrap on every tick
    cfg_start(3'b100, 2, 0, 5, 1'b0);
    run_count(20, hi, no, nm, nb, fo, fm);
    chk("prd0_ovf", no, 9);
    chk("prd0_cnt", cnt, 0);
    chk("prd0_hi", hi, 20);

    // Disable mid-period, active-low
    cfg_start(3'b100, 2, 9, 3, 1'b1);
    run_count(5, hi, no, nm, nb, fo, fm);
    chk("dis_pre_pin", cmpch, 0);
    chk("dis_pre_cnt", cnt, 2);
    en = 1'b0;
    @(posedge clk); #1;
    chk("dis_pin", cmpch, 1);
    chk("dis_cnt", cnt, 0);
    chk("dis_busy", busy, 0);

    // Async reset between edges
    cfg_start(3'b100, 2, 9, 3, 1'b0);
    run_count(3, hi, no, nm, nb, fo, fm);
    chk("ar_pre_pin", cmpch, 1);
    chk("ar_pre_cnt", cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_pin", cmpch, 0);
    chk("ar_cnt", cnt, 0);
    chk("ar_busy", busy, 0);
    chk("ar_pulses", {match, ovf}, 0);
    rst_n = 1'b1;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
